// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the instruction/data memory arbiter: FSM states,
// grant owner, byte-enable patterns and load/store mode codes.
package mem_arbiter_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int L_S_MODE_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_D = 2'd1,
        ARB_BUSY_I = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_BYTE = 4'b0001;

    localparam logic [L_S_MODE_W-1:0] L_S_WORD   = 3'd0;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF   = 3'd1;
    localparam logic [L_S_MODE_W-1:0] L_S_HALF_U = 3'd2;
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE   = 3'd3;
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE_U = 3'd4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the unified
// memory slave. Handshake: bus_req holds with stable address/data until the
// slave raises bus_ack for one cycle; read data is valid in the ack cycle.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
    parameter int W    = WORD_WIDTH,
    parameter int BE_W = W / 8
);
    logic            bus_req;
    logic            bus_we;
    logic [W-1:0]    bus_addr;
    logic [BE_W-1:0] bus_be;
    logic [W-1:0]    bus_wdata;
    logic            bus_ack;
    logic [W-1:0]    bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_lane.sv
// Little-endian lane logic: byte enables, replicated store data, alignment
// check, and load shift plus sign/zero extension.
module mem_lane import mem_arbiter_pkg::*; #(
    parameter int W    = WORD_WIDTH,
    parameter int BE_W = W / 8
) (
    input  logic [L_S_MODE_W-1:0] mode_i,
    input  logic [1:0]            off_i,
    input  logic [W-1:0]          wdata_i,
    input  logic [W-1:0]          rdata_i,
    output logic [BE_W-1:0]       be_o,
    output logic [W-1:0]          wdata_o,
    output logic [W-1:0]          rdata_o,
    output logic                  misaligned_o
);
    logic [W-1:0] sh;

    assign sh = rdata_i >> {off_i, 3'b000};

    always_comb begin
        be_o         = '0;
        wdata_o      = wdata_i;
        rdata_o      = '0;
        misaligned_o = 1'b0;
        case (mode_i)
            L_S_WORD: begin
                be_o         = BE_W'(BE_WORD);
                misaligned_o = (off_i != 2'd0);
                rdata_o      = sh;
            end
            L_S_HALF, L_S_HALF_U: begin
                be_o         = BE_W'(BE_HALF) << off_i;
                misaligned_o = off_i[0];
                wdata_o      = {(W/16){wdata_i[15:0]}};
                rdata_o      = (mode_i == L_S_HALF) ? {{(W-16){sh[15]}}, sh[15:0]}
                                                    : {{(W-16){1'b0}}, sh[15:0]};
            end
            L_S_BYTE, L_S_BYTE_U: begin
                be_o    = BE_W'(BE_BYTE) << off_i;
                wdata_o = {(W/8){wdata_i[7:0]}};
                rdata_o = (mode_i == L_S_BYTE) ? {{(W-8){sh[7]}}, sh[7:0]}
                                               : {{(W-8){1'b0}}, sh[7:0]};
            end
            // Unknown modes take the error path with no enables.
            default: misaligned_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one req/ack memory bus with
// alternating priority, registered completion pulses and misalignment errors.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int W    = WORD_WIDTH,
    parameter int BE_W = W / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [W-1:0]          if_addr,
    output logic [W-1:0]          if_data,
    output logic                  if_ready,
    input  logic                  d_load_en,
    input  logic                  d_store_en,
    input  logic [W-1:0]          d_addr,
    input  logic [L_S_MODE_W-1:0] d_mode,
    input  logic [W-1:0]          d_wdata,
    output logic [W-1:0]          d_rdata,
    output logic                  d_ready,
    output logic                  d_err,
    mem_arbiter_if.master         bus,
    output arb_state_e            dbg_state_o
);
    arb_state_e            state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    logic                  bus_req_q, bus_req_d;
    logic                  bus_we_q, bus_we_d;
    logic [W-1:0]          bus_addr_q, bus_addr_d;
    logic [BE_W-1:0]       bus_be_q, bus_be_d;
    logic [W-1:0]          bus_wdata_q, bus_wdata_d;
    logic [L_S_MODE_W-1:0] mode_q, mode_d;
    logic [1:0]            off_q, off_d;
    logic [W-1:0]          if_data_q, if_data_d;
    logic [W-1:0]          d_rdata_q, d_rdata_d;
    logic                  if_ready_q, if_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic                  d_err_q, d_err_d;

    logic [L_S_MODE_W-1:0] lane_mode;
    logic [1:0]            lane_off;
    logic [BE_W-1:0]       lane_be;
    logic [W-1:0]          lane_wdata;
    logic [W-1:0]          lane_rdata;
    logic                  lane_misaligned;
    logic                  if_elig, d_elig, pick_d, pick_i;

    // One lane unit: live request fields when granting, latched ones when loading.
    always_comb begin
        lane_mode = mode_q;
        lane_off  = off_q;
        if (state_q == ARB_IDLE) begin
            lane_mode = d_mode;
            lane_off  = d_addr[1:0];
        end
    end

    mem_lane #(.W(W), .BE_W(BE_W)) u_lane (
        .mode_i       (lane_mode),
        .off_i        (lane_off),
        .wdata_i      (d_wdata),
        .rdata_i      (bus.bus_rdata),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .rdata_o      (lane_rdata),
        .misaligned_o (lane_misaligned)
    );

    // A requester whose ready is high is still holding the finished request.
    assign if_elig = if_req & ~if_ready_q;
    assign d_elig  = (d_load_en | d_store_en) & ~d_ready_q;
    assign pick_d  = d_elig & ~((last_grant_q == GRANT_D) & if_elig);
    assign pick_i  = if_elig & ~pick_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        mode_d       = mode_q;
        off_d        = off_q;
        if_data_d    = if_data_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        d_err_d      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_d) begin
                    last_grant_d = GRANT_D;
                    if (lane_misaligned) begin
                        d_ready_d = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end else begin
                        state_d     = ARB_BUSY_D;
                        bus_req_d   = 1'b1;
                        bus_we_d    = d_store_en;
                        bus_addr_d  = {d_addr[W-1:2], 2'b00};
                        bus_be_d    = lane_be;
                        bus_wdata_d = lane_wdata;
                        mode_d      = d_mode;
                        off_d       = d_addr[1:0];
                    end
                end else if (pick_i) begin
                    last_grant_d = GRANT_I;
                    state_d      = ARB_BUSY_I;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = if_addr & ~W'(3);
                    bus_be_d     = '1;
                    bus_wdata_d  = '0;
                end
            end
            ARB_BUSY_D: begin
                if (bus.bus_ack) begin
                    state_d   = ARB_IDLE;
                    bus_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    d_rdata_d = bus_we_q ? '0 : lane_rdata;
                end
            end
            ARB_BUSY_I: begin
                if (bus.bus_ack) begin
                    state_d    = ARB_IDLE;
                    bus_req_d  = 1'b0;
                    if_ready_d = 1'b1;
                    if_data_d  = bus.bus_rdata;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_I;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            mode_q       <= '0;
            off_q        <= '0;
            if_data_q    <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            mode_q       <= mode_d;
            off_q        <= off_d;
            if_data_q    <= if_data_d;
            d_rdata_q    <= d_rdata_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
            d_err_q      <= d_err_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign if_data       = if_data_q;
    assign if_ready      = if_ready_q;
    assign d_rdata       = d_rdata_q;
    assign d_ready       = d_ready_q;
    assign d_err         = d_err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps from the test plan, then random
// single transactions, checked against a byte-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  if_req = 1'b0;
    logic [W-1:0]          if_addr = '0;
    logic [W-1:0]          if_data;
    logic                  if_ready;
    logic                  d_load_en = 1'b0;
    logic                  d_store_en = 1'b0;
    logic [W-1:0]          d_addr = '0;
    logic [L_S_MODE_W-1:0] d_mode = '0;
    logic [W-1:0]          d_wdata = '0;
    logic [W-1:0]          d_rdata;
    logic                  d_ready;
    logic                  d_err;
    arb_state_e            dbg_state;

    mem_arbiter_if #(.W(W)) bus ();

    mem_arbiter #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_data     (if_data),
        .if_ready    (if_ready),
        .d_load_en   (d_load_en),
        .d_store_en  (d_store_en),
        .d_addr      (d_addr),
        .d_mode      (d_mode),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ready     (d_ready),
        .d_err       (d_err),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- bus slave driver ----------------
    typedef struct {
        logic         is_d;
        logic         we;
        logic [W-1:0] addr;
        logic [3:0]   be;
        logic [W-1:0] wdata;
    } txn_t;

    txn_t         txn_q[$];
    txn_t         cap;
    logic         slave_en = 1'b1;
    int           slave_wait = 0;
    int           wait_cnt = 0;
    logic [W-1:0] slave_rdata = '0;
    logic         slave_ack = 1'b0;
    logic [W-1:0] slave_rdata_o = '0;
    logic         force_ack = 1'b0;
    logic [W-1:0] force_rdata = '0;

    assign bus.bus_ack   = slave_en ? slave_ack : force_ack;
    assign bus.bus_rdata = slave_en ? slave_rdata_o : force_rdata;

    always @(negedge clk) begin
        if (slave_en) begin
            slave_ack = 1'b0;
            if (bus.bus_req) begin
                if (wait_cnt == 0) begin
                    cap.is_d  = (dbg_state == ARB_BUSY_D);
                    cap.we    = bus.bus_we;
                    cap.addr  = bus.bus_addr;
                    cap.be    = bus.bus_be;
                    cap.wdata = bus.bus_wdata;
                end else begin
                    check("bus_hold_ctl", W'({bus.bus_we, bus.bus_be}), W'({cap.we, cap.be}));
                    check("bus_hold_addr", bus.bus_addr, cap.addr);
                    check("bus_hold_wdata", bus.bus_wdata, cap.wdata);
                end
                if (wait_cnt == slave_wait) begin
                    slave_ack     = 1'b1;
                    slave_rdata_o = slave_rdata;
                    txn_q.push_back(cap);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // ---------------- completion monitor ----------------
    logic [W-1:0] if_q[$];
    logic [W:0]   d_q[$];
    logic [W-1:0] exp_q[$];
    logic         if_ready_prev = 1'b0;
    logic         d_ready_prev = 1'b0;

    always @(negedge clk) begin
        if (if_ready) begin
            check("if_ready_pulse", W'(if_ready_prev), '0);
            if_q.push_back(if_data);
        end
        if (d_ready) begin
            check("d_ready_pulse", W'(d_ready_prev), '0);
            d_q.push_back({d_err, d_rdata});
        end
        if (d_err) check("d_err_with_ready", W'(d_ready), W'(1));
        if_ready_prev = if_ready;
        d_ready_prev  = d_ready;
    end

    // ---------------- reference model ----------------
    bit           mdl_last_d = 1'b0;
    txn_t         last_txn;
    logic [W-1:0] last_rd = '0;

    function automatic void model_data(input logic [L_S_MODE_W-1:0] mode,
                                       input logic [W-1:0] addr, input logic [W-1:0] wdata,
                                       input logic [W-1:0] rdata, output bit err,
                                       output logic [3:0] be, output logic [W-1:0] bwd,
                                       output logic [W-1:0] res);
        int size;
        bit sgn;
        int o;
        logic [W-1:0] mask;
        logic [W-1:0] v;
        o = int'(addr[1:0]);
        size = 0;
        sgn = 1'b0;
        case (mode)
            L_S_WORD:   size = 4;
            L_S_HALF:   begin size = 2; sgn = 1'b1; end
            L_S_HALF_U: size = 2;
            L_S_BYTE:   begin size = 1; sgn = 1'b1; end
            L_S_BYTE_U: size = 1;
            default:    size = 0;
        endcase
        be = '0;
        bwd = '0;
        res = '0;
        if (size == 0) err = 1'b1;
        else err = (o % size) != 0;
        if (!err) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= o && i < o + size) be[i] = 1'b1;
                bwd[8*i +: 8] = wdata[8*(i % size) +: 8];
            end
            mask = (size == 4) ? '1 : ((W'(1) << (8 * size)) - W'(1));
            v = (rdata >> (8 * o)) & mask;
            if (sgn && v[8*size-1]) v = v | ~mask;
            res = v;
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_zero(input string tag);
        check({tag, "_bus_ctl"}, W'({bus.bus_req, bus.bus_we, bus.bus_be}), '0);
        check({tag, "_bus_addr"}, bus.bus_addr, '0);
        check({tag, "_bus_wdata"}, bus.bus_wdata, '0);
        check({tag, "_if_data"}, if_data, '0);
        check({tag, "_d_rdata"}, d_rdata, '0);
        check({tag, "_ready"}, W'({if_ready, d_ready, d_err}), '0);
        check({tag, "_state"}, W'(dbg_state), W'(ARB_IDLE));
    endtask

    task automatic do_fetch(input logic [W-1:0] addr, input logic [W-1:0] rdata, input int k);
        int n_txn;
        int n_if;
        int lat;
        txn_t t;
        n_txn = txn_q.size();
        n_if = if_q.size();
        slave_wait = k;
        slave_rdata = rdata;
        if_addr = addr;
        if_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if_ready && lat < 40);
        check("i_latency", lat, 2 + k);
        @(posedge clk);
        #1 if_req = 1'b0;
        @(negedge clk);
        mdl_last_d = 1'b0;
        check("i_no_regrant", W'(bus.bus_req), '0);
        check("i_txn_count", txn_q.size() - n_txn, 1);
        if (txn_q.size() > n_txn) begin
            t = txn_q[txn_q.size()-1];
            check("i_txn_kind", W'({t.is_d, t.we}), '0);
            check("i_bus_addr", t.addr, addr);
            check("i_bus_be", W'(t.be), W'(4'b1111));
        end
        exp_q.push_back(rdata);
        if (if_q.size() > n_if) check("if_data", if_q[if_q.size()-1], exp_q.pop_front());
        else void'(exp_q.pop_front());
    endtask

    task automatic do_data(input bit store, input logic [L_S_MODE_W-1:0] mode,
                           input logic [W-1:0] addr, input logic [W-1:0] wdata,
                           input logic [W-1:0] rdata, input int k);
        bit err;
        logic [3:0] be;
        logic [W-1:0] bwd;
        logic [W-1:0] res;
        logic [W:0] dv;
        int n_txn;
        int n_d;
        int lat;
        txn_t t;
        model_data(mode, addr, wdata, rdata, err, be, bwd, res);
        n_txn = txn_q.size();
        n_d = d_q.size();
        slave_wait = k;
        slave_rdata = rdata;
        d_addr = addr;
        d_mode = mode;
        d_wdata = wdata;
        d_store_en = store;
        d_load_en = store ? 1'($urandom_range(0, 1)) : 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d_ready && lat < 40);
        check("d_latency", lat, err ? 1 : 2 + k);
        @(posedge clk);
        #1;
        d_load_en = 1'b0;
        d_store_en = 1'b0;
        @(negedge clk);
        mdl_last_d = 1'b1;
        check("d_no_regrant", W'(bus.bus_req), '0);
        check("d_txn_count", txn_q.size() - n_txn, err ? 0 : 1);
        if (!err && txn_q.size() > n_txn) begin
            t = txn_q[txn_q.size()-1];
            last_txn = t;
            check("d_txn_kind", W'({t.is_d, t.we}), W'({1'b1, store}));
            check("d_bus_addr", t.addr, {addr[W-1:2], 2'b00});
            check("d_bus_be", W'(t.be), W'(be));
            if (store) check("d_bus_wdata", t.wdata, bwd);
        end
        check("d_ready_count", d_q.size() - n_d, 1);
        if (d_q.size() > n_d) begin
            dv = d_q[d_q.size()-1];
            last_rd = dv[W-1:0];
            check("d_err", W'(dv[W]), W'(err));
            if (err || !store) check("d_rdata", dv[W-1:0], res);
        end
    endtask

    // Both requesters held until n completions; the grant issued in the last
    // ready cycle must still complete after both requests are withdrawn.
    task automatic do_dual(input int n, input logic [W-1:0] daddr);
        int n_txn;
        int rdy;
        int cyc;
        bit first_d;
        txn_t t;
        n_txn = txn_q.size();
        first_d = !mdl_last_d;
        slave_wait = int'($urandom_range(0, 3));
        slave_rdata = $urandom();
        d_addr = daddr;
        d_mode = L_S_WORD;
        d_load_en = 1'b1;
        d_store_en = 1'b0;
        if_addr = 32'h0000_0400;
        if_req = 1'b1;
        rdy = 0;
        cyc = 0;
        while (rdy < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (if_ready) rdy++;
            if (d_ready) rdy++;
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
        d_load_en = 1'b0;
        repeat (12) @(negedge clk);
        check("dual_txn_count", txn_q.size() - n_txn, n + 1);
        for (int i = 0; i < n + 1 && n_txn + i < txn_q.size(); i++) begin
            t = txn_q[n_txn+i];
            check("dual_order", W'(t.is_d), W'((i % 2 == 0) ? first_d : !first_d));
        end
        check("dual_idle", W'(dbg_state), W'(ARB_IDLE));
        mdl_last_d = (n % 2 == 0) ? first_d : !first_d;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int cyc;
        int kind;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        do_dual(5, 32'h0000_0300);
        do_fetch(32'h0000_0100, 32'h2402_000A, 2);
        do_data(1'b1, L_S_BYTE, 32'h0000_0203, 32'h1234_5678, 32'h0, 1);
        check("spec_byte_be", W'(last_txn.be), W'(4'b1000));
        check("spec_byte_wdata", last_txn.wdata, 32'h7878_7878);
        do_data(1'b0, L_S_HALF, 32'h0000_0202, 32'h0, 32'h8001_FFFF, 0);
        check("spec_half", last_rd, 32'hFFFF_8001);
        do_data(1'b0, L_S_HALF_U, 32'h0000_0202, 32'h0, 32'h8001_FFFF, 3);
        check("spec_half_u", last_rd, 32'h0000_8001);
        do_data(1'b0, L_S_BYTE_U, 32'h0000_0203, 32'h0, 32'h8001_FFFF, 1);
        check("spec_byte_u", last_rd, 32'h0000_0080);
        do_data(1'b0, L_S_WORD, 32'h0000_0201, 32'h0, 32'hDEAD_BEEF, 0);
        do_data(1'b1, 3'd7, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 0);

        // Reset during a data transaction, then a late ack.
        slave_en = 1'b0;
        d_addr = 32'h0000_0300;
        d_mode = L_S_WORD;
        d_load_en = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.bus_req && cyc < 10);
        check("rst_mid_busy", W'(dbg_state), W'(ARB_BUSY_D));
        rst_n = 1'b0;
        d_load_en = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        rst_n = 1'b1;
        force_ack = 1'b1;
        force_rdata = $urandom();
        @(negedge clk);
        force_ack = 1'b0;
        check("late_ack_bus", W'(bus.bus_req), '0);
        check("late_ack_state", W'(dbg_state), W'(ARB_IDLE));
        @(negedge clk);
        check("late_ack_ready", W'({if_ready, d_ready, d_err}), '0);
        slave_en = 1'b1;
        mdl_last_d = 1'b0;

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                do_fetch($urandom() & ~W'(3), $urandom(), int'($urandom_range(0, 3)));
            end else begin
                do_data(kind == 2, L_S_MODE_W'($urandom_range(0, 6)), $urandom(), $urandom(),
                        $urandom(), int'($urandom_range(0, 3)));
            end
        end

        // A misaligned access counts as a data grant, so fetch must go first.
        do_data(1'b0, L_S_HALF, 32'h0000_0511, 32'h0, 32'h0, 0);
        do_dual(4, 32'h0000_0600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares a single-port, word-wide memory bus between the instruction-fetch stage and the memory stage. It arbitrates between the two requesters, drives a req/ack bus transaction, and produces byte enables and lane-replicated write data for sub-word stores. Load data is lane-aligned and sign- or zero-extended before it is returned. The block sits between the pipeline and the unified memory/bus slave, and its ready pulses gate the pipeline stall logic.

## Interface
- `W`, default `WORD_WIDTH` (32): data/address width.
- `BE_W`, default `W/8` (4): byte-enable width.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  W  fetch address, word aligned.
- `if_data`  out  W  fetched word; valid while `if_ready`=1.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `d_load_en`, `d_store_en`  in  1 each  data request; held until `d_ready`.
- `d_addr`  in  W  byte address.
- `d_mode`  in  `L_S_MODE_W`  WORD / HALF / HALF_U / BYTE / BYTE_U.
- `d_wdata`  in  W  raw store value; the low bits are significant.
- `d_rdata`  out  W  aligned, extended load result; valid while `d_ready`=1.
- `d_ready`  out  1  one-cycle completion pulse for data.
- `d_err`  out  1  misaligned access; asserted only together with `d_ready`.
- `bus_req`  out  1  transaction active.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  W  word address, `{addr[W-1:2],2'b00}`.
- `bus_be`  out  BE_W  byte enables.
- `bus_wdata`  out  W  lane-replicated write data.
- `bus_ack`  in  1  slave completion; for reads, `bus_rdata` is valid in the same cycle.
- `bus_rdata`  in  W  read word.

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I.
- A requester is eligible in IDLE only if its request is high and its own ready output is low in that cycle. This masking prevents a duplicate grant on the held request.
- Priority:
  - Data wins by default.
  - If `last_grant`=data and fetch is eligible, fetch wins.
  - `last_grant` updates on every grant.
- On grant, the block registers `bus_addr`, `bus_we`, `bus_be`, `bus_wdata`, mode and `addr[1:0]`, and enters BUSY_x with `bus_req`=1.
- Bus outputs stay stable until `bus_ack`. Requester inputs are not resampled during the transaction; a withdrawn request still completes and still pulses ready.
- On `bus_ack` in BUSY_x:
  - capture the result into `if_data` or `d_rdata`;
  - pulse the matching ready for one cycle;
  - return to IDLE.
- `bus_ack` seen in IDLE is ignored.
- Both `d_load_en` and `d_store_en` high: treated as a store.
- Byte enables and lanes (little-endian, `o` = `addr[1:0]`):
  - WORD: `be`=1111, requires o=0.
  - HALF: `be`=0011<<o, requires o[0]=0, write data `{2{wdata[15:0]}}`.
  - BYTE: `be`=0001<<o, write data `{4{wdata[7:0]}}`.
- Load result: `bus_rdata >> (8*o)`, then sign- or zero-extend from bit 15 or bit 7 according to mode.
- Misaligned data access:
  - no bus transaction is issued;
  - the next cycle pulses `d_ready`=1 and `d_err`=1 with `d_rdata`=0;
  - counts as a data grant.
- Unknown `d_mode`: `be`=0000, no bus cycle, same path as misaligned (`d_err`=1).

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `last_grant`=fetch. All outputs are 0: `bus_req`, `bus_we`, `bus_addr`, `bus_be`, `bus_wdata`, `if_data`, `d_rdata`, both readys, `d_err`.
- Reset mid-transaction aborts immediately. A late `bus_ack` is ignored.
- Request eligible in IDLE at cycle t gives `bus_req`=1 at t+1.
- `bus_ack` at cycle t+1+k gives ready, with data registered, at t+2+k, and state IDLE at t+2+k.
- Earliest next `bus_req` is t+3+k. Minimum 3 cycles per transaction with a zero-wait slave.
- Misaligned access: eligible at t gives `d_ready`/`d_err` at t+1 and no `bus_req`.
- Ready outputs are always registered. No combinational path from `bus_ack` to `if_ready`/`d_ready`.

## Structure
- `defines.v` holds the shared constants:
  - `ARB_IDLE` / `ARB_BUSY_D` / `ARB_BUSY_I` state encodings (2 bits);
  - `BE_WORD`, `BE_HALF`, `BE_BYTE`;
  - the existing `L_S_*` mode codes.
- One combinational sub-module, `mem_lane`, computes `be`, replicated write data, the misaligned flag, and load shift/extend from (mode, `addr[1:0]`, wdata, rdata). The FSM, registers and arbitration live in `mem_arbiter`.

## Test plan
- Fetch only: `if_req`, `if_addr`=0x100, slave acks 2 cycles after `bus_req` with 0x2402000A. Expect `bus_addr`=0x100, `bus_be`=1111, `bus_we`=0, then a one-cycle `if_ready` with `if_data`=0x2402000A and no second grant.
- Simultaneous `if_req` and `d_load_en` from reset (`last_grant`=fetch). Expect data served first, then fetch. With both held continuously afterwards, grants alternate D, I, D, I.
- Store BYTE, `d_addr`=0x203, `d_wdata`=0x12345678. Expect `bus_addr`=0x200, `bus_be`=1000, `bus_wdata`=0x78787878, `bus_we`=1.
- Load HALF at 0x202 with `bus_rdata`=0x8001_FFFF. Expect `d_rdata`=0xFFFF8001; HALF_U gives 0x00008001; BYTE_U at 0x203 gives 0x00000080.
- Load WORD at 0x201. Expect no `bus_req`, and one cycle later `d_ready`=1, `d_err`=1, `d_rdata`=0.
- Drop `rst_n` while in BUSY_D with `bus_req`=1, then ack the next cycle. Expect all outputs 0, state IDLE, no ready pulse.
